// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with valid/ready handshake and an optional 2-entry skid buffer.
// Control bits read as NOP whenever the stage is empty; data bits are held for debug.
module pipe_skid_stage #(
    parameter int unsigned CTRL_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [CTRL_W-1:0] in_ctrl_mask,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d;
    logic [DATA_W-1:0] head_data_q, head_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic              acc;
    logic              pop;
    logic [CTRL_W-1:0] in_ctrl_masked;

    // Without the skid entry, ready must look through to the consumer.
    always_comb begin
        in_ready = in_ready_q;
        if (SKID == 0) begin
            in_ready = (state_q == ST_EMPTY) || out_ready;
        end
    end

    assign out_valid    = (state_q != ST_EMPTY);
    assign out_ctrl     = head_ctrl_q;
    assign out_data     = head_data_q;
    assign occupancy    = OCC_W'(state_q);
    assign stall_cycles = stall_q;

    assign acc            = in_valid && in_ready;
    assign pop            = out_valid && out_ready;
    assign in_ctrl_masked = in_ctrl & in_ctrl_mask;

    // Next-state: head_ctrl is zeroed on every path into EMPTY so out_ctrl needs no gating.
    always_comb begin
        state_d     = state_q;
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            state_d     = ST_EMPTY;
            head_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        head_ctrl_d = in_ctrl_masked;
                        head_data_d = in_data;
                        state_d     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (acc && pop) begin
                        head_ctrl_d = in_ctrl_masked;
                        head_data_d = in_data;
                    end else if (acc) begin
                        skid_ctrl_d = in_ctrl_masked;
                        skid_data_d = in_data;
                        state_d     = ST_FULL;
                    end else if (pop) begin
                        head_ctrl_d = '0;
                        state_d     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        head_ctrl_d = skid_ctrl_q;
                        head_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        state_d     = ST_ONE;
                    end
                end
                default: begin
                    state_d     = ST_EMPTY;
                    head_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d = (state_d != ST_FULL);
    end

    // Saturating back-pressure counter; flush does not clear it.
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            head_ctrl_q <= '0;
            head_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: skid, no-skid and 2-bit-counter instances share stimulus.
module tb_pipe_skid_stage;

    localparam int unsigned CTRL_W = 8;
    localparam int unsigned DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic [CTRL_W-1:0] in_ctrl;
    logic [CTRL_W-1:0] in_ctrl_mask;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              a_in_ready, a_out_valid;
    logic [CTRL_W-1:0] a_out_ctrl;
    logic [DATA_W-1:0] a_out_data;
    logic [1:0]        a_occ;
    logic [15:0]       a_stall;

    logic              b_in_ready, b_out_valid;
    logic [CTRL_W-1:0] b_out_ctrl;
    logic [DATA_W-1:0] b_out_data;
    logic [1:0]        b_occ;
    logic [15:0]       b_stall;

    logic              c_in_ready, c_out_valid;
    logic [CTRL_W-1:0] c_out_ctrl;
    logic [DATA_W-1:0] c_out_data;
    logic [1:0]        c_occ;
    logic [1:0]        c_stall;

    int checks   = 0;
    int failures = 0;

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_ctrl_mask(in_ctrl_mask), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_ctrl(a_out_ctrl),
        .out_data(a_out_data), .occupancy(a_occ), .stall_cycles(a_stall));

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(0), .CNT_W(16)) u_b (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_ctrl_mask(in_ctrl_mask), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_ctrl(b_out_ctrl),
        .out_data(b_out_data), .occupancy(b_occ), .stall_cycles(b_stall));

    pipe_skid_stage #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .SKID(1), .CNT_W(2)) u_c (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_ctrl(in_ctrl), .in_ctrl_mask(in_ctrl_mask), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_ctrl(c_out_ctrl),
        .out_data(c_out_data), .occupancy(c_occ), .stall_cycles(c_stall));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_ctrl      = '0;
        in_ctrl_mask = '1;
        in_data      = '0;
        out_ready    = 1'b0;

        // reset values; in_valid ignored while reset is high
        drive(1'b1, 8'h77, 32'h7777);
        tick();
        tick();
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("rst_out_data",  64'(a_out_data),  64'd0);
        chk("rst_occ",       64'(a_occ),       64'd0);
        chk("rst_stall",     64'(a_stall),     64'd0);
        drive(1'b0, 8'h00, 32'h0);
        reset = 1'b0;
        tick();
        chk("rel_in_ready",  64'(a_in_ready),  64'd1);
        chk("rel_out_valid", 64'(a_out_valid), 64'd0);

        // stream four beats with out_ready high
        out_ready = 1'b1;
        drive(1'b1, 8'h01, 32'h10);
        #1;
        chk("lat_no_comb_valid", 64'(a_out_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'(i + 1), 32'(32'h10 + i));
            tick();
            chk("stream_valid", 64'(a_out_valid), 64'd1);
            chk("stream_ctrl",  64'(a_out_ctrl),  64'(i + 1));
            chk("stream_data",  64'(a_out_data),  64'(32'h10 + i));
        end
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk("stream_drain_valid", 64'(a_out_valid), 64'd0);
        chk("stream_drain_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("stream_drain_hold",  64'(a_out_data),  64'h13);
        chk("stream_stall",       64'(a_stall),     64'd0);

        // back-pressure: two beats accepted, third held upstream
        out_ready = 1'b0;
        drive(1'b1, 8'h21, 32'h101);
        tick();
        chk("bp_occ1",      64'(a_occ),      64'd1);
        chk("bp_ready1",    64'(a_in_ready), 64'd1);
        drive(1'b1, 8'h22, 32'h102);
        tick();
        chk("bp_occ2",      64'(a_occ),      64'd2);
        chk("bp_ready2",    64'(a_in_ready), 64'd0);
        chk("bp_stall1",    64'(a_stall),    64'd1);
        drive(1'b1, 8'h23, 32'h103);
        tick();
        chk("bp_hold_occ",  64'(a_occ),      64'd2);
        chk("bp_hold_ctrl", 64'(a_out_ctrl), 64'h21);
        tick();
        chk("bp_stall3",    64'(a_stall),    64'd3);
        out_ready = 1'b1;
        tick();
        chk("bp_out2_ctrl", 64'(a_out_ctrl), 64'h22);
        chk("bp_out2_data", 64'(a_out_data), 64'h102);
        chk("bp_out2_occ",  64'(a_occ),      64'd1);
        chk("bp_out2_rdy",  64'(a_in_ready), 64'd1);
        tick();
        drive(1'b0, 8'h00, 32'h0);
        chk("bp_out3_ctrl", 64'(a_out_ctrl), 64'h23);
        chk("bp_out3_data", 64'(a_out_data), 64'h103);
        tick();
        chk("bp_end_valid", 64'(a_out_valid), 64'd0);
        chk("bp_end_stall", 64'(a_stall),     64'd3);

        // flush while FULL drops both entries and the presented beat
        out_ready = 1'b0;
        drive(1'b1, 8'h31, 32'hAAAA_0000);
        tick();
        drive(1'b1, 8'h32, 32'hBBBB_0000);
        tick();
        chk("fl_pre_occ",  64'(a_occ),      64'd2);
        chk("fl_pre_data", 64'(a_out_data), 64'hAAAA_0000);
        flush = 1'b1;
        drive(1'b1, 8'h33, 32'hCCCC_0000);
        tick();
        flush = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        chk("fl_valid", 64'(a_out_valid), 64'd0);
        chk("fl_ctrl",  64'(a_out_ctrl),  64'd0);
        chk("fl_data",  64'(a_out_data),  64'hAAAA_0000);
        chk("fl_occ",   64'(a_occ),       64'd0);
        chk("fl_ready", 64'(a_in_ready),  64'd1);
        out_ready = 1'b1;
        tick();
        tick();
        chk("fl_no_ghost_valid", 64'(a_out_valid), 64'd0);
        chk("fl_no_ghost_data",  64'(a_out_data),  64'hAAAA_0000);

        // control mask clears masked bits, data passes through
        in_ctrl_mask = 8'hFE;
        drive(1'b1, 8'hFF, 32'hDEAD_BEEF);
        tick();
        chk("mask_ctrl", 64'(a_out_ctrl), 64'hFE);
        chk("mask_data", 64'(a_out_data), 64'hDEAD_BEEF);
        in_ctrl_mask = 8'hFF;
        drive(1'b0, 8'h00, 32'h0);
        tick();

        // SKID=0: combinational ready, simultaneous acc and pop
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        drive(1'b1, 8'h51, 32'h51);
        #1;
        chk("ns_ready_empty", 64'(b_in_ready), 64'd1);
        tick();
        drive(1'b1, 8'h52, 32'h52);
        #1;
        chk("ns_ready_blocked", 64'(b_in_ready), 64'd0);
        chk("ns_occ1",          64'(b_occ),      64'd1);
        tick();
        chk("ns_hold_ctrl", 64'(b_out_ctrl), 64'h51);
        out_ready = 1'b1;
        #1;
        chk("ns_ready_comb", 64'(b_in_ready), 64'd1);
        tick();
        chk("ns_accpop_occ",  64'(b_occ),      64'd1);
        chk("ns_accpop_ctrl", 64'(b_out_ctrl), 64'h52);
        chk("ns_accpop_data", 64'(b_out_data), 64'h52);
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk("ns_empty_valid", 64'(b_out_valid), 64'd0);
        chk("ns_empty_ctrl",  64'(b_out_ctrl),  64'd0);

        // 2-bit stall counter saturates, then reset mid-operation
        reset = 1'b1;
        out_ready = 1'b0;
        tick();
        reset = 1'b0;
        drive(1'b1, 8'h61, 32'h61);
        tick();
        drive(1'b1, 8'h62, 32'h62);
        tick();
        drive(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 5; i++) tick();
        chk("sat_stall", 64'(c_stall), 64'd3);
        chk("sat_occ",   64'(c_occ),   64'd2);
        reset = 1'b1;
        drive(1'b1, 8'h63, 32'h63);
        tick();
        chk("mrst_valid", 64'(c_out_valid), 64'd0);
        chk("mrst_ctrl",  64'(c_out_ctrl),  64'd0);
        chk("mrst_data",  64'(c_out_data),  64'd0);
        chk("mrst_occ",   64'(c_occ),       64'd0);
        chk("mrst_stall", 64'(c_stall),     64'd0);
        reset = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        tick();
        chk("mrst_ready", 64'(c_in_ready),  64'd1);
        chk("mrst_idle",  64'(c_out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
